shift_rx: RTL and testbench

Serial-in, parallel-out receiver. It is the receive end of the shift-register serial link: it samples a one-bit stream on cin and assembles WIDTH-bit words, MSB-first or LSB-first. Completed words go into a holding register with a valid/ack handshake and overrun detection. It sits between the serial pin and a byte-wide consumer.

---
 rtl/shift_rx.sv | 154 +++++++++++++++
 tb/tb_shift_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/shift_rx.sv
// Serial-in/parallel-out receiver: WIDTH-bit frames (plus an even-parity bit when PARITY_EN is defined) land in PD
// after the completion edge; valid is held until ack, and a completion while a word is still pending sets ovr (no stalling).
module shift_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             dir,
  input  logic             cin,
  output logic [WIDTH-1:0] PD,
  output logic             valid,
  input  logic             ack,
  output logic             busy,
  output logic             ovr,
  output logic             perr
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef PARITY_EN
  localparam logic [1:0] PAR   = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] pd_q, pd_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
`ifdef PARITY_EN
  logic             perr_q, perr_d;
`endif

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dir_d   = dir_q;
    pd_d    = pd_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    ovr_d   = ovr_q;
`ifdef PARITY_EN
    perr_d  = perr_q;
`endif
    done    = 1'b0;
    word    = sr_q;
    shifted = dir_q ? {cin, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], cin};

    case (state_q)
      IDLE: begin
        if (start) begin
          dir_d   = dir;
          // Load rather than shift so stale bits of the previous frame never leak in.
          sr_d    = dir ? {cin, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, cin};
          cnt_d   = CW'(1);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = shifted;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
`ifdef PARITY_EN
          state_d = PAR;
`else
          done    = 1'b1;
          word    = shifted;
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end
      end
`ifdef PARITY_EN
      PAR: begin
        done    = 1'b1;
        word    = sr_q;
        perr_d  = (^sr_q) ^ cin;
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
`endif
      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // An ack coinciding with completion consumes the old word: no overrun, ovr left as is.
    if (done) begin
      pd_d    = word;
      valid_d = 1'b1;
      if (valid_q && !ack) begin
        ovr_d = 1'b1;
      end
    end else if (ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dir_q   <= 1'b0;
      pd_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dir_q   <= dir_d;
      pd_q    <= pd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
`ifdef PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign PD    = pd_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign ovr   = ovr_q;
`ifdef PARITY_EN
  assign perr  = perr_q;
`else
  assign perr  = 1'b0;
`endif

endmodule

// File: tb/tb_shift_rx.sv
// Directed + randomized bench for shift_rx; expectations come from a word-level model of the link.
module tb_shift_rx;
  localparam int W = 8;
`ifdef PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic         cin = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] PD;
  logic         valid, busy, ovr, perr;

  shift_rx #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .dir(dir), .cin(cin),
    .PD(PD), .valid(valid), .ack(ack), .busy(busy), .ovr(ovr), .perr(perr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Word-level model of the holding register
  logic [W-1:0] m_pd = '0;
  bit           m_valid = 1'b0;
  bit           m_ovr = 1'b0;
  bit           m_perr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input bit exp_busy);
    chk({tag, "_pd"},    32'(PD),    32'(m_pd));
    chk({tag, "_valid"}, 32'(valid), 32'(m_valid));
    chk({tag, "_ovr"},   32'(ovr),   32'(m_ovr));
    chk({tag, "_busy"},  32'(busy),  32'(exp_busy));
    chk({tag, "_perr"},  32'(perr),  32'(m_perr));
  endtask

  // Sends one frame back-to-back with whatever preceded it; mid-frame start/dir are randomized noise.
  task automatic frame(input string tag, input logic [W-1:0] w, input logic d,
                       input bit ack_last, input bit inj);
    int n;
    n = PAR_ON ? W + 1 : W;
    for (int i = 0; i < n; i++) begin
      start = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      dir   = (i == 0) ? d : 1'($urandom_range(0, 1));
      if (i < W) cin = d ? w[i] : w[W-1-i];
      else       cin = (^w) ^ inj;
      ack   = ack_last && (i == n - 1);
      tick();
      if (i < n - 1) begin
        chk({tag, "_busy_mid"},  32'(busy),  32'd1);
        chk({tag, "_valid_mid"}, 32'(valid), 32'(m_valid));
        chk({tag, "_pd_mid"},    32'(PD),    32'(m_pd));
      end else begin
        if (!ack_last && m_valid) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_pd    = w;
        m_perr  = PAR_ON ? inj : 1'b0;
        chk_all(tag, 1'b0);
      end
    end
    start = 1'b0;
    ack   = 1'b0;
  endtask

  task automatic idle(input string tag, input bit a);
    start = 1'b0;
    ack   = a;
    cin   = 1'($urandom_range(0, 1));
    dir   = 1'($urandom_range(0, 1));
    tick();
    if (a && m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    chk_all(tag, 1'b0);
    ack = 1'b0;
  endtask

  task automatic model_reset();
    m_pd = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rw;
    logic         rd;
    bit           ra;
    int           gap;

    // Reset state
    rstn = 1'b0; start = 1'b1; cin = 1'b1; ack = 1'b1;
    tick();
    tick();
    model_reset();
    chk_all("reset", 1'b0);
    rstn = 1'b1; start = 1'b0; ack = 1'b0;
    idle("post_reset", 1'b0);

    // MSB-first 0x55
    frame("msb55", 8'h55, 1'b0, 1'b0, 1'b0);
    idle("ack55", 1'b1);

    // LSB-first 0x0F then ack; PD must hold
    frame("lsb0f", 8'h0F, 1'b1, 1'b0, 1'b0);
    idle("ack0f", 1'b1);
    idle("hold0f", 1'b0);

    // Back-to-back without ack -> overrun, then ack clears it
    frame("b2b_aa", 8'hAA, 1'b0, 1'b0, 1'b0);
    frame("b2b_3c", 8'h3C, 1'b0, 1'b0, 1'b0);
    idle("ack_ovr", 1'b1);

    // Completion coincident with ack while a word is pending
    frame("pend_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    frame("cmpl_ack", 8'h96, 1'b1, 1'b1, 1'b0);
    idle("ack96", 1'b1);

    // Mid-frame reset discards the partial word and overrides start/ack
    frame("pre_rst", 8'h7E, 1'b0, 1'b0, 1'b0);
    start = 1'b1; dir = 1'b0; cin = 1'b1; tick();
    start = 1'b0; cin = 1'b0; tick();
    start = 1'b1; cin = 1'b1; tick();
    chk("partial_busy", 32'(busy), 32'd1);
    rstn = 1'b0; start = 1'b1; cin = 1'b1; ack = 1'b1;
    tick();
    rstn = 1'b1; start = 1'b0; ack = 1'b0;
    model_reset();
    chk_all("midrst", 1'b0);
    frame("fresh_c3", 8'hC3, 1'b0, 1'b0, 1'b0);
    idle("ackc3", 1'b1);

    // Randomized traffic: words, bit order, acks and gaps
    for (int k = 0; k < 40; k++) begin
      rw  = W'($urandom);
      rd  = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 3) == 0);
      frame("rnd", rw, rd, ra, 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle("rnd_gap", 1'($urandom_range(0, 1)));
    end
    idle("rnd_flush", 1'b1);

`ifdef PARITY_EN
    frame("par_ff", 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("par_ff_perr", 32'(perr), 32'd0);
    frame("par_01", 8'h01, 1'b0, 1'b1, 1'b1);
    chk("par_01_perr", 32'(perr), 32'd1);
    idle("par_ack", 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
